// File: rtl/tw_buf_multistage_if.sv
// Twiddle buffer bus: stage-controller / write-port side to buffer side.
// The master drives the read sequencing and write inputs. The slave is the
// buffer, which returns the twiddle outputs.
interface tw_buf_multistage_if #(
    parameter int SC_WIDTH   = 3,
    parameter int NUM_STAGES = 3,
    parameter int P_WIDTH    = 128,
    parameter int DEPTH      = 4,
    parameter int GROUPS     = 4
);
    localparam int HW = P_WIDTH / 2;
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int IW = $clog2(DEPTH);

    logic                CEN;
    logic [SC_WIDTH-1:0] stage_counter;
    logic                rd_en;
    logic                wr_en;
    logic                wr_hi;
    logic [SW-1:0]       wr_stage;
    logic [GW-1:0]       wr_grp;
    logic [IW-1:0]       wr_idx;
    logic [HW-1:0]       wr_data;
    logic                const_wr_en;
    logic [P_WIDTH-1:0]  Q;
    logic                Q_valid;
    logic [P_WIDTH-1:0]  Q_const;
    logic [GW-1:0]       grp_idx;
    logic                sweep_done;

    modport master (
        output CEN, stage_counter, rd_en, wr_en, wr_hi, wr_stage, wr_grp,
               wr_idx, wr_data, const_wr_en,
        input  Q, Q_valid, Q_const, grp_idx, sweep_done
    );

    modport slave (
        input  CEN, stage_counter, rd_en, wr_en, wr_hi, wr_stage, wr_grp,
               wr_idx, wr_data, const_wr_en,
        output Q, Q_valid, Q_const, grp_idx, sweep_done
    );
endinterface

// File: rtl/tw_buf_multistage.sv
// Multi-stage twiddle-factor buffer for the radix-16 NTT/FFT butterflies.
// Stores NUM_STAGES x GROUPS x DEPTH packed twiddles plus one constant twiddle
// per stage. Reads self-sequence through the entries of the current group. The
// group advances after GRP_SWEEPS complete sweeps. Writes load one half-word
// per cycle.
// Build option: define TW_WR_BYPASS_EN to forward a same-edge write into the
// read data. With the macro undefined, a read that collides with a write
// returns the stored value from before the write.
module tw_buf_multistage #(
    parameter int SC_WIDTH   = 3,
    parameter int NUM_STAGES = 3,
    parameter int P_WIDTH    = 128,
    parameter int HW         = P_WIDTH / 2,
    parameter int DEPTH      = 4,
    parameter int GROUPS     = 4,
    parameter int GRP_SWEEPS = 16
) (
    input  logic              CLK,
    input  logic              rst_n,
    tw_buf_multistage_if.slave bus
);
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int IW = $clog2(DEPTH);
    localparam int CW = (GRP_SWEEPS > 1) ? $clog2(GRP_SWEEPS) : 1;

    localparam logic [P_WIDTH-1:0] IDENT    = {HW'(1), HW'(1)};
    localparam logic [IW-1:0]      LAST_IDX = IW'(DEPTH - 1);
    localparam logic [GW-1:0]      LAST_GRP = GW'(GROUPS - 1);
    localparam logic [CW-1:0]      LAST_SW  = CW'(GRP_SWEEPS - 1);

    logic [P_WIDTH-1:0]  mem_q [NUM_STAGES][GROUPS][DEPTH];
    logic [P_WIDTH-1:0]  mem_d [NUM_STAGES][GROUPS][DEPTH];
    logic [P_WIDTH-1:0]  cst_q [NUM_STAGES];
    logic [P_WIDTH-1:0]  cst_d [NUM_STAGES];
    logic [P_WIDTH-1:0]  q_q, q_d, q_const_q, q_const_d;
    logic                q_valid_q, q_valid_d, sweep_done_q, sweep_done_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       sweep_q, sweep_d;
    logic [GW-1:0]       grp_q, grp_d;
    logic [SC_WIDTH-1:0] prev_stage_q, prev_stage_d;

    logic                stage_ok, wr_ok, stage_chg;
    logic [SW-1:0]       rd_stage;
    logic [IW-1:0]       e_idx;
    logic [CW-1:0]       e_sw;
    logic [GW-1:0]       e_grp;
    logic [P_WIDTH-1:0]  rd_word, rd_const;

    assign stage_ok  = {1'b0, bus.stage_counter} < (SC_WIDTH + 1)'(NUM_STAGES);
    assign wr_ok     = {1'b0, bus.wr_stage} < (SW + 1)'(NUM_STAGES);
    assign rd_stage  = bus.stage_counter[SW-1:0];
    assign stage_chg = bus.stage_counter != prev_stage_q;
    // A new stage starts its sequence from entry 0 of group 0 on the same edge.
    assign e_idx     = stage_chg ? '0 : idx_q;
    assign e_sw      = stage_chg ? '0 : sweep_q;
    assign e_grp     = stage_chg ? '0 : grp_q;

    // Half-word write into the twiddle and constant stores.
    always_comb begin
        mem_d = mem_q;
        cst_d = cst_q;
        if (bus.wr_en && wr_ok) begin
            if (bus.wr_hi) mem_d[bus.wr_stage][bus.wr_grp][bus.wr_idx][P_WIDTH-1:HW] = bus.wr_data;
            else           mem_d[bus.wr_stage][bus.wr_grp][bus.wr_idx][HW-1:0]       = bus.wr_data;
        end
        if (bus.const_wr_en && wr_ok) begin
            if (bus.wr_hi) cst_d[bus.wr_stage][P_WIDTH-1:HW] = bus.wr_data;
            else           cst_d[bus.wr_stage][HW-1:0]       = bus.wr_data;
        end
    end

`ifdef TW_WR_BYPASS_EN
    assign rd_word  = mem_d[rd_stage][e_grp][e_idx];
    assign rd_const = cst_d[rd_stage];
`else
    assign rd_word  = mem_q[rd_stage][e_grp][e_idx];
    assign rd_const = cst_q[rd_stage];
`endif

    // Read sequencing: entry, sweep and group counters plus the output registers.
    always_comb begin
        q_d          = q_q;
        q_valid_d    = 1'b0;
        q_const_d    = q_const_q;
        idx_d        = idx_q;
        sweep_d      = sweep_q;
        grp_d        = grp_q;
        sweep_done_d = 1'b0;
        prev_stage_d = bus.stage_counter;
        if (!stage_ok) begin
            q_d     = IDENT;
            idx_d   = '0;
            sweep_d = '0;
            grp_d   = '0;
        end else begin
            idx_d   = e_idx;
            sweep_d = e_sw;
            grp_d   = e_grp;
            if (bus.CEN) begin
                q_d = IDENT;
            end else begin
                q_const_d = rd_const;
                if (bus.rd_en) begin
                    q_d       = rd_word;
                    q_valid_d = 1'b1;
                    idx_d     = (e_idx == LAST_IDX) ? '0 : e_idx + 1'b1;
                    if (e_idx == LAST_IDX) begin
                        sweep_done_d = 1'b1;
                        if (e_sw == LAST_SW) begin
                            sweep_d = '0;
                            grp_d   = (e_grp == LAST_GRP) ? '0 : e_grp + 1'b1;
                        end else begin
                            sweep_d = e_sw + 1'b1;
                        end
                    end
                end else begin
                    // A paused read restarts the sweep but keeps its group position.
                    idx_d = '0;
                end
            end
        end
    end

    // State registers. Reset also drops any write presented on the same edge.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                cst_q[s] <= IDENT;
                for (int g = 0; g < GROUPS; g++)
                    for (int i = 0; i < DEPTH; i++)
                        mem_q[s][g][i] <= IDENT;
            end
            q_q          <= '0;
            q_valid_q    <= 1'b0;
            q_const_q    <= IDENT;
            idx_q        <= '0;
            sweep_q      <= '0;
            grp_q        <= '0;
            sweep_done_q <= 1'b0;
            prev_stage_q <= '0;
        end else begin
            mem_q        <= mem_d;
            cst_q        <= cst_d;
            q_q          <= q_d;
            q_valid_q    <= q_valid_d;
            q_const_q    <= q_const_d;
            idx_q        <= idx_d;
            sweep_q      <= sweep_d;
            grp_q        <= grp_d;
            sweep_done_q <= sweep_done_d;
            prev_stage_q <= prev_stage_d;
        end
    end

    assign bus.Q          = q_q;
    assign bus.Q_valid    = q_valid_q;
    assign bus.Q_const    = q_const_q;
    assign bus.grp_idx    = grp_q;
    assign bus.sweep_done = sweep_done_q;
endmodule

// File: tb/tb_tw_buf_multistage.sv
// Testbench for tw_buf_multistage. A reference model tracks each stage's read
// position as one linear count. Entry, sweep and group are derived from that
// count arithmetically.
module tb_tw_buf_multistage;
    localparam int D = 4, S = 16, G = 4, NS = 3;
    localparam logic [127:0] IDENT = {64'd1, 64'd1};

    logic CLK = 1'b0;
    logic rst_n;
    tw_buf_multistage_if bus ();

    tw_buf_multistage dut (.CLK(CLK), .rst_n(rst_n), .bus(bus));

    always #5 CLK = ~CLK;

    int total = 0, bad = 0;

    logic [127:0] m [NS][G][D];
    logic [127:0] c [NS];
    logic [127:0] exp_q, exp_qc;
    logic         exp_v, exp_sd;
    int           pos, prev_st;

    function automatic int exp_grp();
        return (pos / (D * S)) % G;
    endfunction

    task automatic apply_writes();
        if (bus.wr_en && bus.wr_stage < NS) begin
            if (bus.wr_hi) m[bus.wr_stage][bus.wr_grp][bus.wr_idx][127:64] = bus.wr_data;
            else           m[bus.wr_stage][bus.wr_grp][bus.wr_idx][63:0]   = bus.wr_data;
        end
        if (bus.const_wr_en && bus.wr_stage < NS) begin
            if (bus.wr_hi) c[bus.wr_stage][127:64] = bus.wr_data;
            else           c[bus.wr_stage][63:0]   = bus.wr_data;
        end
    endtask

    task automatic model_update();
        int st;
        st = int'(bus.stage_counter);
        if (!rst_n) begin
            for (int s = 0; s < NS; s++) begin
                c[s] = IDENT;
                for (int g = 0; g < G; g++)
                    for (int i = 0; i < D; i++) m[s][g][i] = IDENT;
            end
            exp_q = '0; exp_v = 0; exp_qc = IDENT; exp_sd = 0; pos = 0; prev_st = 0;
            return;
        end
        exp_sd = 0;
`ifdef TW_WR_BYPASS_EN
        apply_writes();
`endif
        if (st >= NS) begin
            exp_q = IDENT; exp_v = 0; pos = 0;
        end else begin
            if (st != prev_st) pos = 0;
            if (bus.CEN) begin
                exp_q = IDENT; exp_v = 0;
            end else begin
                exp_qc = c[st];
                if (bus.rd_en) begin
                    exp_q  = m[st][(pos / D / S) % G][pos % D];
                    exp_v  = 1;
                    exp_sd = (pos % D) == D - 1;
                    pos    = (pos + 1) % (D * S * G);
                end else begin
                    exp_v = 0;
                    pos   = pos - (pos % D);
                end
            end
        end
        prev_st = st;
`ifndef TW_WR_BYPASS_EN
        apply_writes();
`endif
    endtask

    task automatic step();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic idle();
        bus.CEN = 1; bus.rd_en = 0; bus.wr_en = 0; bus.const_wr_en = 0;
        bus.wr_hi = 0; bus.wr_stage = 0; bus.wr_grp = 0; bus.wr_idx = 0; bus.wr_data = '0;
    endtask

    task automatic do_reset();
        idle();
        bus.stage_counter = 0;
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    task automatic write_half(input int s, input int g, input int i, input bit hi, input logic [63:0] d);
        bus.wr_en = 1; bus.wr_hi = hi; bus.wr_stage = 2'(s); bus.wr_grp = 2'(g);
        bus.wr_idx = 2'(i); bus.wr_data = d;
        step();
        bus.wr_en = 0;
    endtask

    task automatic test_reset();
        idle();
        bus.stage_counter = 0;
        rst_n = 0;
        step();
        step();
        total++; if (bus.Q !== 128'd0) begin bad++; $display("FAIL reset_q got=%h want=0", bus.Q); end
        total++; if (bus.Q_valid !== 1'b0) begin bad++; $display("FAIL reset_qv got=%b want=0", bus.Q_valid); end
        total++; if (bus.Q_const !== IDENT) begin bad++; $display("FAIL reset_qc got=%h want=%h", bus.Q_const, IDENT); end
        total++; if (bus.grp_idx !== 2'd0) begin bad++; $display("FAIL reset_grp got=%0d want=0", bus.grp_idx); end
        total++; if (bus.sweep_done !== 1'b0) begin bad++; $display("FAIL reset_sd got=%b want=0", bus.sweep_done); end
        rst_n = 1;
        bus.CEN = 0; bus.rd_en = 1;
        step();
        total++; if (bus.Q !== IDENT || bus.Q_valid !== 1'b1) begin
            bad++; $display("FAIL reset_read got=%h/%b want=%h/1", bus.Q, bus.Q_valid, IDENT); end
    endtask

    task automatic test_load_read();
        logic [127:0] e [D];
        do_reset();
        for (int i = 0; i < D; i++) begin
            e[i] = {32'($urandom), 32'h0000_00A0 + 32'(i), 32'($urandom), 32'h0000_00A0 + 32'(i)};
            write_half(0, 0, i, 1, e[i][127:64]);
            write_half(0, 0, i, 0, e[i][63:0]);
        end
        bus.CEN = 0; bus.rd_en = 1; bus.stage_counter = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            total++; if (bus.Q !== e[k % D] || bus.Q_valid !== 1'b1) begin
                bad++; $display("FAIL load_read k=%0d got=%h/%b want=%h/1", k, bus.Q, bus.Q_valid, e[k % D]); end
            total++; if (bus.sweep_done !== (k == 3)) begin
                bad++; $display("FAIL load_sweep_done k=%0d got=%b want=%b", k, bus.sweep_done, k == 3); end
        end
    endtask

    task automatic test_group_advance();
        do_reset();
        for (int s = 1; s < NS; s++)
            for (int g = 0; g < G; g++)
                for (int i = 0; i < D; i++) begin
                    write_half(s, g, i, 1, {$urandom, $urandom});
                    write_half(s, g, i, 0, {$urandom, $urandom});
                end
        bus.CEN = 0; bus.rd_en = 1; bus.stage_counter = 1;
        for (int k = 1; k <= D * S * G; k++) begin
            step();
            total++; if (int'(bus.grp_idx) !== (k / (D * S)) % G) begin
                bad++; $display("FAIL grp_adv k=%0d got=%0d want=%0d", k, bus.grp_idx, (k / (D * S)) % G); end
            total++; if (bus.Q !== exp_q || bus.sweep_done !== (k % D == 0)) begin
                bad++; $display("FAIL grp_adv_q k=%0d got=%h/%b want=%h/%b", k, bus.Q, bus.sweep_done, exp_q, k % D == 0); end
        end
    endtask

    task automatic test_drop_and_change();
        logic [127:0] held;
        for (int k = 0; k < D * S + 2; k++) step();
        held = bus.Q;
        bus.rd_en = 0;
        step();
        total++; if (bus.Q_valid !== 1'b0 || bus.Q !== held) begin
            bad++; $display("FAIL drop_hold got=%h/%b want=%h/0", bus.Q, bus.Q_valid, held); end
        total++; if (bus.grp_idx !== 2'd1) begin bad++; $display("FAIL drop_grp got=%0d want=1", bus.grp_idx); end
        bus.rd_en = 1;
        step();
        total++; if (bus.Q !== m[1][1][0] || bus.Q_valid !== 1'b1 || bus.grp_idx !== 2'd1) begin
            bad++; $display("FAIL resume got=%h/%b/%0d want=%h/1/1", bus.Q, bus.Q_valid, bus.grp_idx, m[1][1][0]); end
        step();
        bus.stage_counter = 2;
        step();
        total++; if (bus.Q !== m[2][0][0] || bus.grp_idx !== 2'd0) begin
            bad++; $display("FAIL stage_change got=%h/%0d want=%h/0", bus.Q, bus.grp_idx, m[2][0][0]); end
    endtask

    task automatic test_cen_invalid();
        logic [127:0] qc_held;
        for (int k = 0; k < D * S + 3; k++) step();
        bus.CEN = 1;
        step();
        total++; if (bus.Q !== IDENT || bus.Q_valid !== 1'b0 || bus.grp_idx !== 2'd1) begin
            bad++; $display("FAIL cen_off got=%h/%b/%0d want=%h/0/1", bus.Q, bus.Q_valid, bus.grp_idx, IDENT); end
        bus.CEN = 0;
        step();
        total++; if (bus.Q !== exp_q || bus.Q !== m[2][1][0]) begin
            bad++; $display("FAIL cen_frozen got=%h want=%h", bus.Q, m[2][1][0]); end
        qc_held = bus.Q_const;
        bus.stage_counter = 5;
        step();
        total++; if (bus.Q !== IDENT || bus.Q_valid !== 1'b0 || bus.grp_idx !== 2'd0 || bus.Q_const !== qc_held) begin
            bad++; $display("FAIL bad_stage got=%h/%b/%0d/%h want=%h/0/0/%h", bus.Q, bus.Q_valid, bus.grp_idx, bus.Q_const, IDENT, qc_held); end
        bus.stage_counter = 2;
        step();
        total++; if (bus.Q !== m[2][0][0]) begin bad++; $display("FAIL bad_stage_resume got=%h want=%h", bus.Q, m[2][0][0]); end
    endtask

    task automatic test_collision();
        logic [63:0] hi_old, lo_new;
        logic [127:0] want, want_c;
        do_reset();
        hi_old = {$urandom, $urandom};
        lo_new = {$urandom, $urandom};
        write_half(0, 0, 0, 1, hi_old);
        bus.CEN = 0; bus.rd_en = 1; bus.stage_counter = 0;
        bus.wr_en = 1; bus.const_wr_en = 1; bus.wr_hi = 0; bus.wr_stage = 0;
        bus.wr_grp = 0; bus.wr_idx = 0; bus.wr_data = lo_new;
        step();
        bus.wr_en = 0; bus.const_wr_en = 0;
`ifdef TW_WR_BYPASS_EN
        want = {hi_old, lo_new}; want_c = {64'd1, lo_new};
`else
        want = {hi_old, 64'd1};  want_c = IDENT;
`endif
        total++; if (bus.Q !== want) begin bad++; $display("FAIL collide_q got=%h want=%h", bus.Q, want); end
        total++; if (bus.Q_const !== want_c) begin bad++; $display("FAIL collide_qc got=%h want=%h", bus.Q_const, want_c); end
        bus.rd_en = 0;
        step();
        bus.rd_en = 1;
        step();
        total++; if (bus.Q !== {hi_old, lo_new} || bus.Q_const !== {64'd1, lo_new}) begin
            bad++; $display("FAIL collide_after got=%h/%h want=%h/%h", bus.Q, bus.Q_const, {hi_old, lo_new}, {64'd1, lo_new}); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            bus.CEN = ($urandom_range(0, 9) == 0);
            bus.rd_en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 29) == 0) bus.stage_counter = 3'($urandom_range(0, 4));
            bus.wr_en = ($urandom_range(0, 2) == 0);
            bus.const_wr_en = ($urandom_range(0, 5) == 0);
            bus.wr_hi = 1'($urandom);
            bus.wr_stage = 2'($urandom_range(0, 3));
            bus.wr_grp = 2'($urandom);
            bus.wr_idx = 2'($urandom);
            bus.wr_data = {$urandom, $urandom};
            rst_n = ($urandom_range(0, 199) != 0);
            step();
            rst_n = 1;
            total++; if (bus.Q !== exp_q || bus.Q_valid !== exp_v) begin
                bad++; $display("FAIL rand_q k=%0d got=%h/%b want=%h/%b", k, bus.Q, bus.Q_valid, exp_q, exp_v); end
            total++; if (bus.Q_const !== exp_qc) begin
                bad++; $display("FAIL rand_qc k=%0d got=%h want=%h", k, bus.Q_const, exp_qc); end
            total++; if (int'(bus.grp_idx) !== exp_grp() || bus.sweep_done !== exp_sd) begin
                bad++; $display("FAIL rand_grp k=%0d got=%0d/%b want=%0d/%b", k, bus.grp_idx, bus.sweep_done, exp_grp(), exp_sd); end
        end
    endtask

    initial begin
        rst_n = 0;
        idle();
        bus.stage_counter = 0;
        test_reset();
        test_load_read();
        test_group_advance();
        test_drop_and_change();
        test_cen_invalid();
        test_collision();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
